scr1_tb_ahb_stall_bridge: RTL

Single-outstanding AHB-Lite bridge inserted between the core's data-memory AHB master port and the testbench AHB memory model. It registers each master transfer, holds the master in its data phase for a programmable number of extra wait cycles, and replays the transfer to the memory. It then returns read data and the OKAY or ERROR response. Its purpose is to stress core LSU stall handling beyond the memory model's own stall settings.

---
 rtl/scr1_tb_ahb_stall_bridge_pkg.sv | 25 ++
 rtl/scr1_tb_ahb_stall_bridge.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/scr1_tb_ahb_stall_bridge_pkg.sv
// Shared AHB-Lite encodings and helpers for the testbench stall bridge.
package scr1_tb_ahb_stall_bridge_pkg;

  localparam int SCR1_AHB_WIDTH = 32;

  localparam logic [1:0] SCR1_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] SCR1_HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] SCR1_HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] SCR1_HTRANS_SEQ    = 2'b11;

  localparam logic SCR1_HRESP_OKAY  = 1'b0;
  localparam logic SCR1_HRESP_ERROR = 1'b1;

  // BUSY and IDLE carry no transfer and are never forwarded.
  function automatic logic htrans_active(input logic [1:0] htrans);
    logic act;
    case (htrans)
      SCR1_HTRANS_IDLE, SCR1_HTRANS_BUSY: act = 1'b0;
      SCR1_HTRANS_NONSEQ, SCR1_HTRANS_SEQ: act = 1'b1;
      default: act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/scr1_tb_ahb_stall_bridge.sv
// Single-outstanding AHB-Lite bridge: registers a master transfer, stretches the
// master data phase by stall_cycles extra waits, then replays it to the memory.
//
// state | meaning
// IDLE  | no transfer, master may issue
// WAIT  | counting down programmed extra wait cycles
// ADDR  | address phase driven to memory (NONSEQ)
// DATA  | memory data phase, waiting for s_hready
// RESP  | OKAY completion to master, may accept next transfer
// ERR1  | first ERROR cycle to master (hready low)
// ERR2  | second ERROR cycle to master, may accept next transfer
module scr1_tb_ahb_stall_bridge
  import scr1_tb_ahb_stall_bridge_pkg::*;
#(
  parameter int AHB_WIDTH = SCR1_AHB_WIDTH,
  parameter int STALL_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall_cycles,
  input  logic [1:0]           m_htrans,
  input  logic [2:0]           m_hsize,
  input  logic [AHB_WIDTH-1:0] m_haddr,
  input  logic                 m_hwrite,
  input  logic [AHB_WIDTH-1:0] m_hwdata,
  output logic                 m_hready,
  output logic [AHB_WIDTH-1:0] m_hrdata,
  output logic                 m_hresp,
  output logic [1:0]           s_htrans,
  output logic [2:0]           s_hsize,
  output logic [AHB_WIDTH-1:0] s_haddr,
  output logic                 s_hwrite,
  output logic [AHB_WIDTH-1:0] s_hwdata,
  input  logic                 s_hready,
  input  logic [AHB_WIDTH-1:0] s_hrdata,
  input  logic                 s_hresp
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [STALL_W-1:0]   cnt;
  logic [AHB_WIDTH-1:0] addr_r;
  logic [AHB_WIDTH-1:0] wdata_r;
  logic [AHB_WIDTH-1:0] rdata_r;
  logic [2:0]           size_r;
  logic                 write_r;
  logic                 wcap_pend;
  logic                 accept;

  // m_hready is decoded from state only, so accept never loops back combinationally.
  assign accept = m_hready && htrans_active(m_htrans);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_RESP, ST_ERR2: begin
        if (accept) begin
          state_nxt = (stall_cycles != '0) ? ST_WAIT : ST_ADDR;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt <= STALL_W'(1)) begin
          state_nxt = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (s_hready) begin
          state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (s_hready) begin
          state_nxt = (s_hresp == SCR1_HRESP_ERROR) ? ST_ERR1 : ST_RESP;
        end
      end
      ST_ERR1: state_nxt = ST_ERR2;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_hready = 1'b0;
    m_hresp  = SCR1_HRESP_OKAY;
    s_htrans = SCR1_HTRANS_IDLE;
    case (state)
      ST_IDLE, ST_RESP: m_hready = 1'b1;
      ST_ADDR:          s_htrans = SCR1_HTRANS_NONSEQ;
      ST_ERR1:          m_hresp  = SCR1_HRESP_ERROR;
      ST_ERR2: begin
        m_hready = 1'b1;
        m_hresp  = SCR1_HRESP_ERROR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      addr_r    <= '0;
      size_r    <= '0;
      write_r   <= 1'b0;
      wdata_r   <= '0;
      rdata_r   <= '0;
      wcap_pend <= 1'b0;
    end else begin
      if (accept) begin
        addr_r  <= m_haddr;
        size_r  <= m_hsize;
        write_r <= m_hwrite;
        cnt     <= stall_cycles;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - STALL_W'(1);
      end
      // The master's write data is valid in the cycle after accept and held stable.
      wcap_pend <= accept;
      if (wcap_pend) begin
        wdata_r <= m_hwdata;
      end
      if (state == ST_DATA && s_hready && s_hresp == SCR1_HRESP_OKAY) begin
        rdata_r <= s_hrdata;
      end
    end
  end

  assign s_haddr  = addr_r;
  assign s_hsize  = size_r;
  assign s_hwrite = write_r;
  assign s_hwdata = wdata_r;
  assign m_hrdata = rdata_r;

endmodule
